// File: rtl/sdram_rd_fifo_ctrl.sv
// sdram_rd_fifo_ctrl: refills a 2^FIFO_AW-word read FIFO with SDRAM bursts
// walked through a circular address window, and serves user pops from it.
module sdram_rd_fifo_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 21,
    parameter int FIFO_AW = 9,
    parameter int LEN_W   = 9
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                init_end,
    input  logic                read_valid,
    input  logic [ADDR_W-1:0]   rd_b_addr,
    input  logic [ADDR_W-1:0]   rd_e_addr,
    input  logic [LEN_W-1:0]    rd_len_cfg,
    input  logic                rd_addr_clr,
    input  logic                rd_ack,
    input  logic                rd_end,
    input  logic [DATA_W-1:0]   rd_sdram_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [LEN_W-1:0]    rd_burst_len,
    input  logic                rd_fifo_rd_req,
    output logic [DATA_W-1:0]   rd_fifo_rd_data,
    output logic [FIFO_AW:0]    rd_fifo_num,
    output logic                rd_fifo_empty,
    output logic                rd_ovf
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int CW    = FIFO_AW + 2;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]    rd_burst_len_q, rd_burst_len_d;
    logic                clr_pend_q, clr_pend_d;
    logic                init_q, init_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                clr_eff, clr_apply;
    logic                full, empty, push, pop, fill_ok, wrap;
    logic [CW-1:0]       fill_sum;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W:0]     wrap_sum;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign fill_sum  = CW'(cnt_q) + CW'(rd_len_cfg);
    assign fill_ok   = (fill_sum <= CW'(DEPTH));
    assign next_addr = rd_addr_q + ADDR_W'(rd_burst_len_q);
    assign wrap_sum  = {1'b0, next_addr} + (ADDR_W+1)'(rd_burst_len_q);
    assign wrap      = (wrap_sum > {1'b0, rd_e_addr});
    assign clr_eff   = clr_pend_q | rd_addr_clr;

    // Burst request FSM, address walk and pending-clear handling
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        rd_burst_len_d = rd_burst_len_q;
        init_d         = 1'b1;
        clr_apply      = clr_eff &
                         ((state_q == IDLE) ||
                          ((state_q == BUSY) && rd_end));
        clr_pend_d     = clr_eff & ~clr_apply;
        unique case (state_q)
            IDLE: begin
                if (init_end && read_valid && !clr_eff && fill_ok) begin
                    state_d        = REQ;
                    rd_burst_len_d = rd_len_cfg;
                end
            end
            REQ: begin
                if (rd_ack)
                    state_d = BUSY;
            end
            BUSY: begin
                if (rd_end) begin
                    state_d   = IDLE;
                    rd_addr_d = wrap ? rd_b_addr : next_addr;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!init_q || clr_apply)
            rd_addr_d = rd_b_addr;
        rd_en_d = (state_d == REQ);
    end

    // FIFO pointers, occupancy, registered pop data and overflow flag
    always_comb begin
        pop       = rd_fifo_rd_req & ~empty & ~clr_apply;
        push      = rd_ack & (~full | pop) & ~clr_apply;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q | (rd_ack & full & ~pop & ~clr_apply);
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
        if (clr_apply) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // State and control registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            rd_burst_len_q <= '0;
            clr_pend_q     <= 1'b0;
            init_q         <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            rd_data_q      <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            rd_burst_len_q <= rd_burst_len_d;
            clr_pend_q     <= clr_pend_d;
            init_q         <= init_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            rd_data_q      <= rd_data_d;
            ovf_q          <= ovf_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr_q] <= rd_sdram_data;
    end

    assign rd_en           = rd_en_q;
    assign rd_addr         = rd_addr_q;
    assign rd_burst_len    = rd_burst_len_q;
    assign rd_fifo_rd_data = rd_data_q;
    assign rd_fifo_num     = cnt_q;
    assign rd_fifo_empty   = empty;
    assign rd_ovf          = ovf_q;

endmodule

// File: doc/sdram_rd_fifo_ctrl.md
Name: sdram_rd_fifo_ctrl

Overview:
Read-side FIFO controller directly upstream of the SDRAM burst-read engine.
- Watches its internal read FIFO level and issues burst read requests (rd_en, rd_addr, rd_burst_len) to the read engine.
- Captures the returned words, qualified by rd_ack, into the FIFO.
- Advances the SDRAM address in a circular window and presents a FIFO pop interface to the user logic.
- Single clock domain, sys_clk at 100 MHz.

Parameters:
- DATA_W, 32, SDRAM word width.
- ADDR_W, 21, SDRAM address width, {bank[1:0], row[10:0], col[7:0]}.
- FIFO_AW, 9, FIFO address width; depth is 2^FIFO_AW = 512 words.

Ports:
- sys_clk, in, 1, system clock, 100 MHz.
- sys_rst_n, in, 1, asynchronous active-low reset.
- init_end, in, 1, SDRAM initialisation complete.
- read_valid, in, 1, enables automatic refill.
- rd_b_addr, in, 21, window start address.
- rd_e_addr, in, 21, window end address (exclusive).
- rd_len_cfg, in, 9, burst length in words, 1..256.
- rd_addr_clr, in, 1, one-cycle pulse: flush FIFO and rewind to rd_b_addr.
- rd_ack, in, 1, word-valid strobe from the read engine.
- rd_end, in, 1, one-cycle burst-complete strobe from the read engine.
- rd_sdram_data, in, 32, read word, valid when rd_ack=1.
- rd_en, out, 1, burst read request to the read engine.
- rd_addr, out, 21, burst start address.
- rd_burst_len, out, 9, latched burst length.
- rd_fifo_rd_req, in, 1, user pop request.
- rd_fifo_rd_data, out, 32, popped word.
- rd_fifo_num, out, 10, FIFO occupancy, 0..512.
- rd_fifo_empty, out, 1, FIFO empty.
- rd_ovf, out, 1, sticky overflow flag.

Behaviour:
- Reset values (async, all outputs): rd_en=0, rd_addr=0, rd_burst_len=0, rd_fifo_rd_data=0, rd_fifo_num=0, rd_fifo_empty=1, rd_ovf=0, state=IDLE, clr_pend=0.
- First cycle after reset release: rd_addr loads rd_b_addr (init flag).

State machine (IDLE, REQ, BUSY):
- IDLE -> REQ when init_end=1, read_valid=1, clr_pend=0 and rd_fifo_num + rd_len_cfg <= 512.
  - On this transition latch rd_burst_len <= rd_len_cfg.
- REQ: rd_en=1 (registered).
  - Leave for BUSY on the first rd_ack=1; rd_en drops in the same cycle.
  - rd_en must be low before the read engine returns to idle, so no duplicate burst is issued.
- BUSY: rd_en=0; wait for rd_end.
  - On rd_end, return to IDLE and update the address:
  - next = rd_addr + rd_burst_len, computed 21-bit without carry.
  - If next + rd_burst_len > rd_e_addr (22-bit compare), rd_addr <= rd_b_addr; else rd_addr <= next.
- rd_addr and rd_burst_len are stable from entry to REQ until BUSY exits.

FIFO:
- Push when rd_ack=1, data rd_sdram_data. Pop when rd_fifo_rd_req=1 and not empty.
- rd_fifo_rd_data is registered; valid on the cycle after the pop. It holds its value when there is no pop.
- Simultaneous push and pop: count unchanged, both operations are performed. This is also legal when the FIFO is full.
- Push when full with no pop: word dropped, rd_ovf <= 1 (sticky until reset). Cannot happen under correct refill gating.
- Pop when empty: ignored; data and count unchanged.
- rd_fifo_empty = (rd_fifo_num == 0). Pointers wrap modulo 512.

Clear:
- rd_addr_clr sets clr_pend.
- Applied when state is IDLE, or on the rd_end cycle in BUSY:
  - FIFO pointers and count go to 0.
  - rd_addr <= rd_b_addr, overriding the normal advance.
  - clr_pend <= 0.
- No new request is issued while clr_pend=1.
- A clear in REQ/BUSY lets the burst complete; its words are discarded by the flush.
- A clear coinciding with a pop: the flush wins.

Other rules:
- read_valid or init_end dropping mid-burst does not abort the burst. It only blocks the next request.
- A reset mid-burst returns everything to the reset values immediately.

Test Plan:
- Reset, then init_end=1, read_valid=1, rd_b_addr=0, rd_e_addr=1024, rd_len_cfg=256, with the read engine modelled -> rd_en rises; rd_addr=0; after 256 rd_acks and rd_end, rd_fifo_num=256 and rd_addr=256.
- Continue with no pops -> second burst at 256 fills to 512; no third request while rd_fifo_num > 256; rd_ovf=0.
- Window wrap, rd_e_addr=768, len=256 -> burst addresses 0, 256, 512, 0.
- Pop 10 words, including a pop on the same cycle as an rd_ack push, with FIFO at 100 -> count ends at 100-10+pushes; popped data matches push order with 1-cycle latency.
- Pulse rd_addr_clr mid-BUSY -> burst completes; on rd_end, rd_fifo_num=0, rd_fifo_empty=1, rd_addr=rd_b_addr; the next request starts at rd_b_addr.
- Force an rd_ack with the FIFO full -> rd_ovf=1 and stays 1; count stays 512. Assert sys_rst_n=0 mid-burst -> all outputs return to reset values asynchronously.
